// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file sizing constants. Rev 1.0
`default_nettype none

package regfile_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int NUM_REGS = 2 ** RF_ADDR_W;
  localparam int unsigned REG_ZERO = 0;
endpackage

`default_nettype wire

// File: rtl/regfile_sb.sv
// regfile_sb: per-register pending bits tracking issued-but-not-written-back destinations. Rev 1.0
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic             set_valid;
  logic             clr_valid;

  assign set_valid = issue_en && (issue_addr != ZERO_A);
  assign clr_valid = wb_en && (wb_addr != ZERO_A);

  // Clear is applied before set so a same-address issue keeps the bit pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_valid) pending_d[wb_addr] = 1'b0;
    if (set_valid) pending_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rs_busy = pending_q[rs_addr] && !(wb_en && (wb_addr == rs_addr)) && (rs_addr != ZERO_A);
  assign rt_busy = pending_q[rt_addr] && !(wb_en && (wb_addr == rt_addr)) && (rt_addr != ZERO_A);

endmodule

`default_nettype wire

// File: rtl/regfile.sv
// regfile: 2-read/1-write register file with write-first bypass and pending scoreboard. Rev 1.0
`default_nettype none

module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              rs_busy,
  output logic              rt_busy
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_valid;

  // Bypass is suppressed while reset is asserted so reads stay zero.
  assign wr_valid = rst_n && wb_en && (wb_addr != ZERO_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_valid) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_data = regs_q[rs_addr];
    if (rs_addr == ZERO_A) rs_data = '0;
    else if (wr_valid && (wb_addr == rs_addr)) rs_data = wb_data;
  end

  always_comb begin
    rt_data = regs_q[rt_addr];
    if (rt_addr == ZERO_A) rt_data = '0;
    else if (wr_valid && (wb_addr == rt_addr)) rt_data = wb_data;
  end

  regfile_sb #(
    .ADDR_W(ADDR_W)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_busy   (rs_busy),
    .rt_busy   (rt_busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// tb_regfile: directed scoreboard bench for regfile. Rev 1.0
`default_nettype none

module tb_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, wb_addr, issue_addr;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_en, issue_en, rs_busy, rt_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic        rs_b;
    logic        rt_b;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_regs [32];
  logic        m_pend [32];

  regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .rs_busy   (rs_busy),
    .rt_busy   (rt_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (rst_n && wb_en && (wb_addr == a)) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return m_pend[a] && !(wb_en && (wb_addr == a));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag  = tag;
    e.rs_d = exp_data(rs_addr);
    e.rt_d = exp_data(rt_addr);
    e.rs_b = exp_busy(rs_addr);
    e.rt_b = exp_busy(rt_addr);
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb_q.pop_front();
    checks += 4;
    assert (rs_data === e.rs_d) else begin errors++; $error("FAIL %s rs_data got %h exp %h", e.tag, rs_data, e.rs_d); end
    assert (rt_data === e.rt_d) else begin errors++; $error("FAIL %s rt_data got %h exp %h", e.tag, rt_data, e.rt_d); end
    assert (rs_busy === e.rs_b) else begin errors++; $error("FAIL %s rs_busy got %b exp %b", e.tag, rs_busy, e.rs_b); end
    assert (rt_busy === e.rt_b) else begin errors++; $error("FAIL %s rt_busy got %b exp %b", e.tag, rt_busy, e.rt_b); end
  endtask

  task automatic chk32(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin errors++; $error("FAIL %s got %h exp %h", tag, act, exp); end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia, input logic [4:0] ra, input logic [4:0] rb);
    wb_en = we; wb_addr = wa; wb_data = wd;
    issue_en = ie; issue_addr = ia;
    rs_addr = ra; rt_addr = rb;
  endtask

  // One clock cycle: drive, predict, compare before the edge, then advance the model.
  task automatic step(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ie, input logic [4:0] ia, input logic [4:0] ra, input logic [4:0] rb);
    drive(we, wa, wd, ie, ia, ra, rb);
    push_exp(tag);
    @(negedge clk);
    pop_check();
    @(posedge clk);
    if (rst_n) begin
      if (we && wa != 5'd0) begin
        m_regs[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (ie && ia != 5'd0) m_pend[ia] = 1'b1;
    end
    #1;
  endtask

  task automatic peek(input string tag);
    push_exp(tag);
    #1;
    pop_check();
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(1'b1, 5'd7, 32'hCAFE_F00D, 1'b1, 5'd7, 5'd7, 5'd7);
    peek("reset_hold");
    @(posedge clk); #1;
    peek("reset_ignore_wb");
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    rst_n = 1'b1;

    for (int i = 1; i < 32; i++) step("post_reset_read", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i), 5'(i));

    step("wr_r5", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    step("rd_r5", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
    chk32("r5_const", rs_data, 32'hDEAD_BEEF);

    step("bypass_r7", 1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 5'd7, 5'd7);
    chk32("r7_rt_const", rt_data, 32'h1234_5678);

    step("issue_r3", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0);
    step("busy_r3", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
    chk32("r3_busy_const", {31'd0, rs_busy}, 32'd1);
    step("wb_r3", 1'b1, 5'd3, 32'h0000_00A5, 1'b0, 5'd0, 5'd3, 5'd0);
    step("after_wb_r3", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);

    step("issue_r4", 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd0, 5'd0);
    step("set_wins_r4", 1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd4, 5'd4, 5'd4);
    step("r4_still_busy", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
    chk32("r4_busy_const", {31'd0, rs_busy}, 32'd1);
    step("clear_r4", 1'b1, 5'd4, 32'h0000_0045, 1'b0, 5'd0, 5'd0, 5'd0);

    step("r0_ignore", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    step("r0_read", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

    step("split_set_clr", 1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd6, 5'd6, 5'd3);
    step("split_result", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd3);
    step("double_issue_a", 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd0, 5'd0);
    step("double_issue_b", 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd8, 5'd0);
    step("single_clear", 1'b1, 5'd8, 32'h0000_0888, 1'b0, 5'd0, 5'd0, 5'd0);
    step("r8_free", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd6);
    step("wb_nonpending", 1'b1, 5'd10, 32'h0000_0AAA, 1'b0, 5'd0, 5'd0, 5'd0);
    step("r10_read", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10, 5'd10);

    step("wr_r9", 1'b1, 5'd9, 32'h0000_0055, 1'b0, 5'd0, 5'd0, 5'd0);
    step("issue_r9", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9);
    drive(1'b1, 5'd9, 32'h0000_0077, 1'b1, 5'd9, 5'd9, 5'd9);
    #2;
    rst_n = 1'b0;
    model_reset();
    peek("async_reset");
    chk32("r9_reset_const", rs_data, 32'd0);
    @(posedge clk); #1;
    peek("reset_ignore_r9");
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    rst_n = 1'b1;
    step("first_wr_after_rst", 1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd11, 5'd0, 5'd0);
    step("after_rst_read", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd11);

    checks++;
    assert (sb_q.size() == 0) else begin errors++; $error("FAIL sb_drain got %0d exp 0", sb_q.size()); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width (2**ADDR_W registers).
REQ-003 The block SHALL use one clock and asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous reset, active low.
REQ-004 rs_addr  input  ADDR_W  read port A address.
REQ-005 rt_addr  input  ADDR_W  read port B address.
REQ-006 rs_data  output  DATA_W  read port A data.
REQ-007 rt_data  output  DATA_W  read port B data.
REQ-008 wb_en  input  1  writeback strobe from the writeback-select stage.
REQ-009 wb_addr  input  ADDR_W  writeback destination register.
REQ-010 wb_data  input  DATA_W  writeback value (the selected result).
REQ-011 issue_en  input  1  an instruction with a destination register is issued this cycle.
REQ-012 issue_addr  input  ADDR_W  destination of the issued instruction, to be marked pending.
REQ-013 rs_busy  output  1  port A register awaits writeback.
REQ-014 rt_busy  output  1  port B register awaits writeback.

Function
REQ-015 Write: on a rising clk edge with wb_en=1 and wb_addr!=0, reg[wb_addr] SHALL take wb_data; otherwise register contents SHALL hold.
REQ-016 Register 0 SHALL read as 0 always; writes and issues to address 0 SHALL be ignored.
REQ-017 Reads SHALL be combinational, zero-cycle latency.
REQ-018 Bypass: when wb_en=1, wb_addr!=0 and wb_addr equals a read address, that port SHALL output wb_data in the same cycle (write-first); both ports SHALL bypass independently.
REQ-019 Scoreboard: a pending bit per register; on a clk edge with issue_en=1 and issue_addr!=0, pending[issue_addr] SHALL set.
REQ-020 On a clk edge with wb_en=1 and wb_addr!=0, pending[wb_addr] SHALL clear unless the same edge sets it per REQ-019 (set wins).
REQ-021 Set and clear to different addresses on one edge SHALL both take effect.
REQ-022 rs_busy SHALL equal pending[rs_addr] AND NOT (wb_en AND wb_addr==rs_addr); rt_busy likewise; both SHALL be 0 for address 0.
REQ-023 Issue to an already-pending register SHALL leave it pending (no counting); one writeback clears it.
REQ-024 Writeback to a non-pending register SHALL still write data; pending stays 0.

Reset
REQ-025 rst_n=0 SHALL immediately clear all registers and pending bits, independent of clk.
REQ-026 During reset rs_data, rt_data SHALL be 0 (bypass excluded) and rs_busy, rt_busy SHALL be 0; wb_en/issue_en SHALL be ignored.
REQ-027 After rst_n deasserts, the first write/issue SHALL take effect on the next rising edge.

Structure
REQ-028 A shared package SHALL hold DATA_W, ADDR_W defaults, NUM_REGS and the REG_ZERO constant.
REQ-029 The pending-bit logic SHALL be one sub-module, regfile_sb; storage and bypass stay in regfile.

Verification
REQ-030 Reset then read r1..r31 -> all data 0, all busy 0.
REQ-031 Write r5=0xDEADBEEF, next cycle read rs=5, rt=0 -> rs_data=0xDEADBEEF, rt_data=0.
REQ-032 wb_en=1 wb_addr=7 wb_data=0x12345678 with rs_addr=rt_addr=7 same cycle -> both ports 0x12345678 before the edge, rs_busy=rt_busy=0.
REQ-033 Issue r3, next cycle rs_addr=3 -> rs_busy=1; writeback r3=0xA5 -> busy 0 and data 0xA5 that cycle; stays 0 after.
REQ-034 Same edge issue_addr=4 and wb_addr=4 with r4 pending -> r4 written, pending stays 1; issue/write to r0 -> reads 0, busy 0.
REQ-035 Write r9=0x55, issue r9, assert rst_n=0 between edges -> r9 reads 0 and busy 0 immediately.
